// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serializer: state codes, the state type
// and the default word width.
// Optional feature macro: PISO_PARITY_EN (adds the PARITY state).
package piso_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    localparam int unsigned PISO_DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
`ifdef PISO_PARITY_EN
        S_PARITY = ST_PARITY,
`endif
        S_SHIFT  = ST_SHIFT
    } state_t;

endpackage

// File: rtl/piso_serializer_if.sv
// Word-source / serial-line bundle for the PISO serializer.
// master = word source side, slave = serializer side.
interface piso_serializer_if
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = PISO_DEF_WIDTH
);

    logic             load;
    logic [WIDTH-1:0] din;
    logic             ready;
    logic             sout;
    logic             frame;
    logic             done;

    modport master (
        output load,
        output din,
        input  ready,
        input  sout,
        input  frame,
        input  done
    );

    modport slave (
        input  load,
        input  din,
        output ready,
        output sout,
        output frame,
        output done
    );

endinterface

// File: rtl/piso_bit_counter.sv
// Loadable down-counter tracking how many data bits remain on the line.
// o_last flags the cycle on which the final bit is being shown.
module piso_bit_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_last
);

    logic [CNT_W-1:0] r_count;

    // Load has priority over decrement; reset over both.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_last = (r_count == CNT_W'(1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter. A word accepted on load&&ready is
// shifted out MSB first, one bit per clock, with frame high while bits are
// on the line and a one-cycle done pulse after the frame.
// Optional feature macro: PISO_PARITY_EN appends one even-parity bit.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = PISO_DEF_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    piso_serializer_if.slave bus
);

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic             r_sout;
    logic             r_frame;
    logic             r_done;
    logic             r_ready;
`ifdef PISO_PARITY_EN
    logic             r_parity;
`endif

    logic w_cnt_load;
    logic w_cnt_dec;
    logic w_last;

    assign w_cnt_load = (r_state == S_IDLE) && bus.load;
    assign w_cnt_dec  = (r_state == S_SHIFT);

    piso_bit_counter #(
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (CNT_W'(WIDTH)),
        .i_dec      (w_cnt_dec),
        .o_last     (w_last)
    );

    // Control FSM with the shift register and all registered outputs.
    // sout is a separate register loaded one bit ahead of the shift
    // register, so the MSB appears on the cycle right after the load edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_sout  <= 1'b0;
            r_frame <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
`ifdef PISO_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.load) begin
                        r_shift <= bus.din;
                        r_sout  <= bus.din[WIDTH-1];
                        r_frame <= 1'b1;
                        r_ready <= 1'b0;
                        r_state <= S_SHIFT;
`ifdef PISO_PARITY_EN
                        r_parity <= ^bus.din;
`endif
                    end else begin
                        r_sout  <= 1'b0;
                        r_frame <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    r_shift <= r_shift << 1;
                    if (w_last) begin
`ifdef PISO_PARITY_EN
                        r_sout  <= r_parity;
                        r_state <= S_PARITY;
`else
                        r_sout  <= 1'b0;
                        r_frame <= 1'b0;
                        r_ready <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
`endif
                    end else begin
                        r_sout <= r_shift[WIDTH-2];
                    end
                end
`ifdef PISO_PARITY_EN
                S_PARITY: begin
                    r_sout  <= 1'b0;
                    r_frame <= 1'b0;
                    r_ready <= 1'b1;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
`endif
                default: begin
                    r_sout  <= 1'b0;
                    r_frame <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready = r_ready;
    assign bus.sout  = r_sout;
    assign bus.frame = r_frame;
    assign bus.done  = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: a table of words with hand-computed
// parity, plus sequences for reset, back-to-back, ignored load, mid-frame
// reset and the WIDTH=2 boundary. Handles both PISO_PARITY_EN builds.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int unsigned FLEN  = 9;
    localparam int unsigned FLEN2 = 3;
`else
    localparam int unsigned FLEN  = 8;
    localparam int unsigned FLEN2 = 2;
`endif

    logic clk;
    logic rst;

    piso_serializer_if #(.WIDTH(8)) bus ();
    piso_serializer_if #(.WIDTH(2)) bus2 ();

    piso_serializer #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    piso_serializer #(.WIDTH(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] din;
        logic       par;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, ".ready"}, 32'(bus.ready), 32'd1);
        chk({nm, ".sout"},  32'(bus.sout),  32'd0);
        chk({nm, ".frame"}, 32'(bus.frame), 32'd0);
        chk({nm, ".done"},  32'(bus.done),  32'd0);
    endtask

    task automatic chk_bit(input string nm, input logic exp_bit);
        chk({nm, ".frame"}, 32'(bus.frame), 32'd1);
        chk({nm, ".sout"},  32'(bus.sout),  32'(exp_bit));
        chk({nm, ".ready"}, 32'(bus.ready), 32'd0);
        chk({nm, ".done"},  32'(bus.done),  32'd0);
    endtask

    task automatic chk_done(input string nm);
        chk({nm, ".done"},  32'(bus.done),  32'd1);
        chk({nm, ".frame"}, 32'(bus.frame), 32'd0);
        chk({nm, ".ready"}, 32'(bus.ready), 32'd1);
        chk({nm, ".sout"},  32'(bus.sout),  32'd0);
    endtask

    // Load one word for a single cycle, check every frame cycle and the done cycle.
    task automatic send_word(input logic [7:0] d, input logic par);
        logic exp_bit;
        bus.din  = d;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        bus.din  = ~d;
        for (int unsigned k = 0; k < FLEN; k++) begin
            exp_bit = (k < 8) ? d[7-k] : par;
            chk_bit($sformatf("word%0h.bit%0d", d, k), exp_bit);
            tick();
        end
        chk_done($sformatf("word%0h.donecyc", d));
        tick();
        chk_idle($sformatf("word%0h.after", d));
    endtask

    initial begin
        logic [7:0] exp_c3;
        logic [7:0] exp_f0;
        logic       exp_bit;

        vecs[0] = '{din: 8'hA5, par: 1'b0};
        vecs[1] = '{din: 8'hC3, par: 1'b0};
        vecs[2] = '{din: 8'h07, par: 1'b1};
        vecs[3] = '{din: 8'h03, par: 1'b0};
        vecs[4] = '{din: 8'hFF, par: 1'b0};
        vecs[5] = '{din: 8'h00, par: 1'b0};
        vecs[6] = '{din: 8'h80, par: 1'b1};
        vecs[7] = '{din: 8'h01, par: 1'b1};
        vecs[8] = '{din: 8'h5B, par: 1'b1};

        rst       = 1'b1;
        bus.load  = 1'b0;
        bus.din   = 8'h00;
        bus2.load = 1'b0;
        bus2.din  = 2'b00;

        // Reset held for two cycles, then idle with load low.
        tick();
        chk_idle("rst.c1");
        tick();
        chk_idle("rst.c2");
        rst = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            chk_idle($sformatf("postrst.c%0d", i));
        end

        // Table of single words.
        for (int unsigned v = 0; v < 9; v++) begin
            send_word(vecs[v].din, vecs[v].par);
        end

        // Back-to-back: load held high; din switches to 00 on the done cycle.
        bus.din  = 8'hFF;
        bus.load = 1'b1;
        tick();
        for (int unsigned k = 0; k < FLEN; k++) begin
            chk_bit($sformatf("b2b.ff.bit%0d", k), (k < 8) ? 1'b1 : 1'b0);
            tick();
        end
        chk_done("b2b.gap");
        bus.din = 8'h00;
        tick();
        bus.load = 1'b0;
        for (int unsigned k = 0; k < FLEN; k++) begin
            chk_bit($sformatf("b2b.00.bit%0d", k), 1'b0);
            tick();
        end
        chk_done("b2b.done2");
        tick();
        chk_idle("b2b.after");

        // Load with a new word in the middle of a C3 frame is ignored.
        exp_c3   = 8'b1100_0011;
        bus.din  = 8'hC3;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int unsigned k = 0; k < FLEN; k++) begin
            exp_bit = (k < 8) ? exp_c3[7-k] : 1'b0;
            chk_bit($sformatf("ign.bit%0d", k), exp_bit);
            if (k == 3) begin
                bus.load = 1'b1;
                bus.din  = 8'h3C;
            end else if (k == 5) begin
                bus.load = 1'b0;
            end
            tick();
        end
        chk_done("ign.done");
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            chk_idle($sformatf("ign.after%0d", i));
        end

        // Reset asserted on frame cycle 4 of F0 aborts the frame with no done.
        exp_f0   = 8'hF0;
        bus.din  = exp_f0;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            chk_bit($sformatf("mrst.bit%0d", k), exp_f0[7-k]);
            if (k == 3) rst = 1'b1;
            tick();
        end
        chk_idle("mrst.abort");
        rst = 1'b0;
        for (int unsigned i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("mrst.nodone%0d", i), 32'(bus.done), 32'd0);
            chk($sformatf("mrst.noframe%0d", i), 32'(bus.frame), 32'd0);
        end

        // WIDTH=2 boundary: din=2'b10, parity 1.
        bus2.din  = 2'b10;
        bus2.load = 1'b1;
        tick();
        bus2.load = 1'b0;
        for (int unsigned k = 0; k < FLEN2; k++) begin
            exp_bit = (k == 1) ? 1'b0 : 1'b1;
            chk($sformatf("w2.frame%0d", k), 32'(bus2.frame), 32'd1);
            chk($sformatf("w2.sout%0d", k),  32'(bus2.sout),  32'(exp_bit));
            chk($sformatf("w2.done%0d", k),  32'(bus2.done),  32'd0);
            chk($sformatf("w2.ready%0d", k), 32'(bus2.ready), 32'd0);
            tick();
        end
        chk("w2.done",  32'(bus2.done),  32'd1);
        chk("w2.frame", 32'(bus2.frame), 32'd0);
        chk("w2.ready", 32'(bus2.ready), 32'd1);
        tick();
        chk("w2.after.done", 32'(bus2.done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
